// File: rtl/glip_channel_arb.sv
// glip_channel_arb: round-robin burst arbiter for one GLIP valid/ready channel.
// Define GLIP_CHANNEL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module glip_channel_arb #(
  parameter int N         = 2,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [N-1:0]    grant_n;
  logic [IW-1:0]   last;
  logic [IW-1:0]   last_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [IW-1:0]   base;
  logic [N-1:0]    cand;
  logic            gv;
  logic            xfer;
  logic            rel;

  // last doubles as the current grant index while granted
`ifdef GLIP_CHANNEL_ARB_FIXED_PRIO_EN
  assign base = IW'(N - 1);
`else
  assign base = last;
`endif

  function automatic logic [IW-1:0] pick(
    input logic [N-1:0]  req,
    input logic [IW-1:0] from
  );
    logic [IW-1:0] r_hi;
    logic [IW-1:0] r_lo;
    logic          hi;
    r_hi = '0;
    r_lo = '0;
    hi   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && i > int'(from)) begin
        r_hi = IW'(i);
        hi   = 1'b1;
      end
      if (req[i] && i <= int'(from)) begin
        r_lo = IW'(i);
      end
    end
    return hi ? r_hi : r_lo;
  endfunction

  function automatic logic [N-1:0] onehot(
    input logic [IW-1:0] idx
  );
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign gv        = |(grant & in_valid);
  assign out_valid = gv;
  assign in_ready  = grant & {N{out_ready}};
  assign xfer      = out_valid && out_ready;
  assign cand      = in_valid & ~grant;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (state == GRANT && last == IW'(i)) begin
        out_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    cnt_n   = cnt;
    rel     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|in_valid) begin
          state_n = GRANT;
          last_n  = pick(in_valid, base);
          grant_n = onehot(last_n);
          cnt_n   = '0;
        end
      end
      GRANT: begin
        rel = (xfer && cnt == CW'(MAX_BURST - 1)) || !gv;
        if (rel) begin
          cnt_n = '0;
          if (|cand) begin
            last_n  = pick(cand, base);
            grant_n = onehot(last_n);
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end else if (xfer) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(N - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: doc/glip_channel_arb.md
# glip_channel_arb

Round-robin arbiter that shares one downstream GLIP valid/ready channel among N upstream requesters. It sits between several producer-side channel masters (e.g. debug-module packet sources) and a single GLIP transmit channel. Grants are held per burst so consecutive words from one requester stay contiguous, up to a bounded burst length. Data and handshake paths are combinational through the granted port; arbitration state is registered.

## Interface
- `N`, default 2: number of requesters, ≥2.
- `WIDTH`, default 16: channel data width.
- `MAX_BURST`, default 8: maximum transfers per grant, ≥1.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_data`, in, N*WIDTH: requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`, in, N: requester valid.
- `in_ready`, out, N: requester ready.
- `out_data`, out, WIDTH: downstream data.
- `out_valid`, out, 1: downstream valid.
- `out_ready`, in, 1: downstream ready.
- `grant`, out, N: one-hot current grant; all-zero when idle.

## Operation
- Transfer: a cycle with `out_valid && out_ready` moves one word from the granted requester.
- States:
  - **IDLE**: `grant`=0, `out_valid`=0, `in_ready`=0, `out_data`=0.
  - **GRANT(g)**: `out_data`=`in_data[g]`, `out_valid`=`in_valid[g]`, `in_ready[g]`=`out_ready`; all other `in_ready` bits are 0.
- Pointer `last`: index of the most recently granted requester.
  - Round-robin search order is `last+1`, `last+2`, … modulo N.
  - `last` resets to N-1, so index 0 wins first.
- IDLE → GRANT(g): any `in_valid` set; g is the first set bit in search order. `last` takes the value g.
- Burst counter `cnt` (width clog2(MAX_BURST+1)):
  - Cleared on every new grant.
  - Incremented on each transfer.
- Release of GRANT(g), evaluated each cycle:
  - (a) a transfer occurs and `cnt`==MAX_BURST-1, or
  - (b) `in_valid[g]`==0.
- On release:
  - Candidates are `in_valid` excluding g.
  - If any candidate exists, go directly to GRANT(next) by round-robin search and clear `cnt`.
  - Otherwise go to IDLE.
- Without release, the state and `cnt` hold. A stalled beat (`out_ready`=0) never triggers release (a).
- MAX_BURST=1: release after every transfer, so strict word interleaving.
- Simultaneous requests: only the search order decides; no requester waits more than (N-1) grants.

## Timing
- Reset (async assert, sync deassert via `clk`):
  - State IDLE, `cnt`=0, `last`=N-1.
  - `grant`=0, `out_valid`=0, `in_ready`=0, `out_data`=0.
- Reset mid-burst aborts the grant immediately. No partial-state recovery.
- Arbitration latency:
  - `in_valid` asserted in IDLE at cycle t gives `grant` and `out_valid` at t+1.
  - The first transfer is possible at t+1.
- Grant switch on release (a) or (b) with another requester pending: the next requester is visible the following cycle. There is no IDLE bubble.
- Data/valid/ready paths: zero-cycle combinational mux. `grant` is a register output.
- `in_ready` never asserts for a non-granted requester. Requesters must hold data stable while valid and not ready.

## Configuration
- `GLIP_CHANNEL_ARB_FIXED_PRIO_EN`:
  - Defined: search order is always 0, 1, …, N-1 (lowest index wins), and `last` is unused. Release rules and MAX_BURST still apply. On release, candidates still exclude the current g, so a continuously requesting higher-priority port gets the grant back only after another grant or IDLE.
  - Undefined (default): round-robin as above.

## Test plan
- Reset: hold `rst_n`=0 with all `in_valid`=1. Expect `grant`=0, `out_valid`=0, `in_ready`=0. Release reset: `grant`=0b01 one cycle later (N=2).
- Burst cap: N=2, MAX_BURST=4, both valid continuously, `out_ready`=1. Expect 4 words from port 0 (0xA000–0xA003), then 4 from port 1 (0xB000–0xB003), alternating with no idle cycle.
- Backpressure: N=2, grant on port 0. `out_ready`=0 for 5 cycles mid-burst. Expect `out_data` stable, `cnt` unchanged, no release; the burst completes at 4 transfers after ready returns.
- Early release: N=3. Port 1 drops `in_valid` after 2 words while ports 0 and 2 request. Expect the grant to move to port 2 the next cycle (round-robin after 1), then port 0.
- Single requester: only port 2 valid (N=3, MAX_BURST=2). Expect `grant`=0b100, 2 transfers, then IDLE for 1 cycle, then re-grant port 2.
- Fixed-priority build (`GLIP_CHANNEL_ARB_FIXED_PRIO_EN` defined): ports 1 and 2 are requesting while IDLE. Expect port 1 granted first, then port 2 on release.
